// File: rtl/forward_ctrl.sv
// Forwarding and load-use hazard control for a 5-stage in-order pipeline.
// It tracks the destinations in EX and MEM and produces registered EX operand selects, a load-use stall and a stall counter.
module forward_ctrl #(
    parameter int REG_W = 5,
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             id_valid_i,
    input  logic [REG_W-1:0] id_rs1_i,
    input  logic [REG_W-1:0] id_rs2_i,
    input  logic             id_use_rs1_i,
    input  logic             id_use_rs2_i,
    input  logic [REG_W-1:0] id_rd_i,
    input  logic             id_regwen_i,
    input  logic             id_memrd_i,
    input  logic             flush_i,
    input  logic             hold_i,
    output logic [1:0]       fwd_a_se_o,
    output logic [1:0]       fwd_b_se_o,
    output logic             stall_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_WB  = 2'b10;

    // EX and MEM tracking registers
    logic             ex_valid_q,  ex_valid_d;
    logic [REG_W-1:0] ex_rd_q,     ex_rd_d;
    logic             ex_regwen_q, ex_regwen_d;
    logic             ex_memrd_q,  ex_memrd_d;
    logic             mem_valid_q,  mem_valid_d;
    logic [REG_W-1:0] mem_rd_q,     mem_rd_d;
    logic             mem_regwen_q, mem_regwen_d;
    logic [1:0]       fwd_a_q, fwd_a_d;
    logic [1:0]       fwd_b_q, fwd_b_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    logic ex_hit_rs1, ex_hit_rs2, mem_hit_rs1, mem_hit_rs2;
    logic load_use;
    logic stall;

    function automatic logic producer_hit(
        input logic             vld,
        input logic             wen,
        input logic [REG_W-1:0] rd,
        input logic [REG_W-1:0] src
    );
        return vld & wen & (rd != '0) & (rd == src);
    endfunction

    // The younger producer (EX) wins over the older one (MEM).
    function automatic logic [1:0] pick_sel(
        input logic use_src,
        input logic ex_hit,
        input logic mem_hit
    );
        if (use_src && ex_hit) begin
            return SEL_MEM;
        end else if (use_src && mem_hit) begin
            return SEL_WB;
        end
        return SEL_RF;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        if (c == {CNT_W{1'b1}}) begin
            return c;
        end
        return c + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    always_comb begin
        ex_hit_rs1  = producer_hit(ex_valid_q, ex_regwen_q, ex_rd_q, id_rs1_i);
        ex_hit_rs2  = producer_hit(ex_valid_q, ex_regwen_q, ex_rd_q, id_rs2_i);
        mem_hit_rs1 = producer_hit(mem_valid_q, mem_regwen_q, mem_rd_q, id_rs1_i);
        mem_hit_rs2 = producer_hit(mem_valid_q, mem_regwen_q, mem_rd_q, id_rs2_i);
        load_use    = id_valid_i & ex_memrd_q &
                      ((id_use_rs1_i & ex_hit_rs1) | (id_use_rs2_i & ex_hit_rs2));
        stall       = load_use & ~flush_i & ~hold_i;
    end

    always_comb begin
        ex_valid_d   = ex_valid_q;
        ex_rd_d      = ex_rd_q;
        ex_regwen_d  = ex_regwen_q;
        ex_memrd_d   = ex_memrd_q;
        mem_valid_d  = mem_valid_q;
        mem_rd_d     = mem_rd_q;
        mem_regwen_d = mem_regwen_q;
        fwd_a_d      = fwd_a_q;
        fwd_b_d      = fwd_b_q;
        cnt_d        = cnt_q;

        if (!hold_i) begin
            mem_valid_d  = ex_valid_q;
            mem_rd_d     = ex_rd_q;
            mem_regwen_d = ex_regwen_q;

            if (flush_i || stall) begin
                ex_valid_d  = 1'b0;
                ex_rd_d     = '0;
                ex_regwen_d = 1'b0;
                ex_memrd_d  = 1'b0;
                fwd_a_d     = SEL_RF;
                fwd_b_d     = SEL_RF;
            end else begin
                ex_valid_d  = id_valid_i;
                ex_rd_d     = id_rd_i;
                ex_regwen_d = id_regwen_i;
                ex_memrd_d  = id_memrd_i;
                fwd_a_d     = pick_sel(id_use_rs1_i, ex_hit_rs1, mem_hit_rs1);
                fwd_b_d     = pick_sel(id_use_rs2_i, ex_hit_rs2, mem_hit_rs2);
            end

            if (stall) begin
                cnt_d = sat_inc(cnt_q);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ex_valid_q   <= 1'b0;
            ex_rd_q      <= '0;
            ex_regwen_q  <= 1'b0;
            ex_memrd_q   <= 1'b0;
            mem_valid_q  <= 1'b0;
            mem_rd_q     <= '0;
            mem_regwen_q <= 1'b0;
            fwd_a_q      <= SEL_RF;
            fwd_b_q      <= SEL_RF;
            cnt_q        <= '0;
        end else begin
            ex_valid_q   <= ex_valid_d;
            ex_rd_q      <= ex_rd_d;
            ex_regwen_q  <= ex_regwen_d;
            ex_memrd_q   <= ex_memrd_d;
            mem_valid_q  <= mem_valid_d;
            mem_rd_q     <= mem_rd_d;
            mem_regwen_q <= mem_regwen_d;
            fwd_a_q      <= fwd_a_d;
            fwd_b_q      <= fwd_b_d;
            cnt_q        <= cnt_d;
        end
    end

    assign fwd_a_se_o  = fwd_a_q;
    assign fwd_b_se_o  = fwd_b_q;
    assign stall_o     = stall;
    assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_forward_ctrl.sv
// Directed bench for forward_ctrl: an instruction-sequence vector table plus hand-written
// sequences for counter saturation and reset during a stall.
module tb_forward_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_use1, id_use2, id_regwen, id_memrd;
    logic       flush, hold;
    logic [1:0] fwd_a, fwd_b;
    logic       stall;
    logic [7:0] stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    forward_ctrl dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .id_valid_i   (id_valid),
        .id_rs1_i     (id_rs1),
        .id_rs2_i     (id_rs2),
        .id_use_rs1_i (id_use1),
        .id_use_rs2_i (id_use2),
        .id_rd_i      (id_rd),
        .id_regwen_i  (id_regwen),
        .id_memrd_i   (id_memrd),
        .flush_i      (flush),
        .hold_i       (hold),
        .fwd_a_se_o   (fwd_a),
        .fwd_b_se_o   (fwd_b),
        .stall_o      (stall),
        .stall_cnt_o  (stall_cnt)
    );

    typedef struct {
        string      name;
        logic       v;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       wen;
        logic       mrd;
        logic       fl;
        logic       hd;
        logic       e_stall;
        logic [1:0] e_fa;
        logic [1:0] e_fb;
        logic [7:0] e_cnt;
    } vec_t;

    vec_t tv[24];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic [4:0] rd,
                         input logic wen, input logic mrd, input logic fl, input logic hd);
        id_valid  = v;
        id_rs1    = rs1;
        id_rs2    = rs2;
        id_use1   = u1;
        id_use2   = u2;
        id_rd     = rd;
        id_regwen = wen;
        id_memrd  = mrd;
        flush     = fl;
        hold      = hd;
    endtask

    int bad_pulses;

    initial begin
        //          name            v  rs1 rs2 u1 u2 rd  wen mrd fl hd  stall fa     fb     cnt
        tv[0]  = '{"add_x5",        1, 1,  2,  1, 1, 5,  1,  0,  0, 0,  0, 2'b00, 2'b00, 8'd0};
        tv[1]  = '{"sub_x6_ex_fwd", 1, 5,  3,  1, 1, 6,  1,  0,  0, 0,  0, 2'b01, 2'b00, 8'd0};
        tv[2]  = '{"nop_a",         0, 0,  0,  0, 0, 0,  0,  0,  0, 0,  0, 2'b00, 2'b00, 8'd0};
        tv[3]  = '{"add_x5_b",      1, 1,  2,  1, 1, 5,  1,  0,  0, 0,  0, 2'b00, 2'b00, 8'd0};
        tv[4]  = '{"nop_b",         0, 0,  0,  0, 0, 0,  0,  0,  0, 0,  0, 2'b00, 2'b00, 8'd0};
        tv[5]  = '{"or_x7_wb_fwd",  1, 4,  5,  1, 1, 7,  1,  0,  0, 0,  0, 2'b00, 2'b10, 8'd0};
        tv[6]  = '{"lw_x8",         1, 1,  0,  1, 0, 8,  1,  1,  0, 0,  0, 2'b00, 2'b00, 8'd0};
        tv[7]  = '{"add_x9_stall",  1, 8,  8,  1, 1, 9,  1,  0,  0, 0,  1, 2'b00, 2'b00, 8'd1};
        tv[8]  = '{"add_x9_retry",  1, 8,  8,  1, 1, 9,  1,  0,  0, 0,  0, 2'b10, 2'b10, 8'd1};
        tv[9]  = '{"add_x0",        1, 1,  2,  1, 1, 0,  1,  0,  0, 0,  0, 2'b00, 2'b00, 8'd1};
        tv[10] = '{"use_x0",        1, 0,  0,  1, 1, 10, 1,  0,  0, 0,  0, 2'b00, 2'b00, 8'd1};
        tv[11] = '{"add_x5_old",    1, 1,  2,  1, 1, 5,  1,  0,  0, 0,  0, 2'b00, 2'b00, 8'd1};
        tv[12] = '{"add_x5_new",    1, 3,  4,  1, 1, 5,  1,  0,  0, 0,  0, 2'b00, 2'b00, 8'd1};
        tv[13] = '{"sub_x11_prio",  1, 5,  0,  1, 1, 11, 1,  0,  0, 0,  0, 2'b01, 2'b00, 8'd1};
        tv[14] = '{"lw_x12",        1, 1,  0,  1, 0, 12, 1,  1,  0, 0,  0, 2'b00, 2'b00, 8'd1};
        tv[15] = '{"lu_flushed",    1, 12, 12, 1, 1, 13, 1,  0,  1, 0,  0, 2'b00, 2'b00, 8'd1};
        tv[16] = '{"lw_x14",        1, 12, 0,  1, 0, 14, 1,  1,  0, 0,  0, 2'b10, 2'b00, 8'd1};
        tv[17] = '{"lu_hold1",      1, 14, 14, 1, 1, 15, 1,  0,  0, 1,  0, 2'b10, 2'b00, 8'd1};
        tv[18] = '{"lu_hold2",      1, 14, 14, 1, 1, 15, 1,  0,  0, 1,  0, 2'b10, 2'b00, 8'd1};
        tv[19] = '{"lu_hold3",      1, 14, 14, 1, 1, 15, 1,  0,  0, 1,  0, 2'b10, 2'b00, 8'd1};
        tv[20] = '{"lu_after_hold", 1, 14, 14, 1, 1, 15, 1,  0,  0, 0,  1, 2'b00, 2'b00, 8'd2};
        tv[21] = '{"lu_retry",      1, 14, 14, 1, 1, 15, 1,  0,  0, 0,  0, 2'b10, 2'b10, 8'd2};
        tv[22] = '{"hold_flush",    1, 15, 0,  1, 0, 16, 1,  0,  1, 1,  0, 2'b10, 2'b10, 8'd2};
        tv[23] = '{"flush_only",    1, 15, 0,  1, 0, 16, 1,  0,  1, 0,  0, 2'b00, 2'b00, 8'd2};

        rst_n = 1'b0;
        drive(1, 1, 1, 1, 1, 1, 1, 1, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_fwd_a", fwd_a, 0);
        chk("rst_fwd_b", fwd_b, 0);
        chk("rst_cnt", stall_cnt, 0);
        chk("rst_stall", stall, 0);

        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Instruction sequence table: stall checked before the edge, registered outputs after it
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            drive(tv[i].v, tv[i].rs1, tv[i].rs2, tv[i].u1, tv[i].u2, tv[i].rd,
                  tv[i].wen, tv[i].mrd, tv[i].fl, tv[i].hd);
            #1;
            chk({tv[i].name, "_stall"}, stall, tv[i].e_stall);
            @(posedge clk);
            #1;
            chk({tv[i].name, "_fwd_a"}, fwd_a, tv[i].e_fa);
            chk({tv[i].name, "_fwd_b"}, fwd_b, tv[i].e_fb);
            chk({tv[i].name, "_cnt"}, stall_cnt, tv[i].e_cnt);
        end

        // 256 more load-use pairs: counter must stop at 255
        bad_pulses = 0;
        for (int k = 0; k < 256; k++) begin
            @(negedge clk);
            drive(1, 2, 0, 1, 0, 1, 1, 1, 0, 0);
            @(negedge clk);
            drive(1, 1, 1, 1, 1, 2, 1, 0, 0, 0);
            #1;
            if (stall !== 1'b1) bad_pulses++;
            @(negedge clk);
            #1;
            if (stall !== 1'b0) bad_pulses++;
        end
        chk("sat_stall_pulses", bad_pulses, 0);
        chk("sat_cnt_255", stall_cnt, 255);

        // Reset asserted in the middle of a stall cycle
        @(negedge clk);
        drive(1, 2, 0, 1, 0, 1, 1, 1, 0, 0);
        @(negedge clk);
        drive(1, 1, 1, 1, 1, 2, 1, 0, 0, 0);
        #1;
        chk("midrst_pre_stall", stall, 1);
        chk("midrst_pre_fwd_a", fwd_a, 1);
        chk("midrst_pre_cnt", stall_cnt, 255);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_cnt", stall_cnt, 0);
        chk("midrst_fwd_a", fwd_a, 0);
        chk("midrst_fwd_b", fwd_b, 0);
        chk("midrst_stall", stall, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("postrst_stall", stall, 0);
        @(posedge clk);
        #1;
        chk("postrst_fwd_a", fwd_a, 0);
        chk("postrst_cnt", stall_cnt, 0);
        @(negedge clk);
        drive(1, 2, 0, 1, 0, 3, 1, 0, 0, 0);
        #1;
        chk("postrst_no_stall", stall, 0);
        @(posedge clk);
        #1;
        chk("postrst_loaded_fwd_a", fwd_a, 1);
        chk("postrst_loaded_cnt", stall_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
